// File: rtl/wb_write_arbiter_pkg.sv
// Shared definitions for the writeback arbiter: default widths and the
// register-write request record.
package wb_write_arbiter_pkg;

    localparam int DEF_DATA_W       = 32;
    localparam int DEF_ADDR_W       = 5;
    localparam int DEF_QDEPTH       = 4;
    localparam int DEF_STARVE_LIMIT = 3;
    localparam int NUM_REGS         = 32;

    typedef struct packed {
        logic [DEF_ADDR_W-1:0] addr;
        logic [DEF_DATA_W-1:0] data;
    } wr_req_t;

endpackage

// File: rtl/wb_write_arbiter_if.sv
// Writeback arbiter bus: ALU result path, long-latency handshake, register-file
// write port and hazard-visibility outputs.
interface wb_write_arbiter_if
    import wb_write_arbiter_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int QDEPTH = DEF_QDEPTH
);
    localparam int CNT_W = $clog2(QDEPTH + 1);

    logic                  alu_valid;
    logic [ADDR_W-1:0]     alu_addr;
    logic [DATA_W-1:0]     alu_data;
    logic                  alu_stall;
    logic                  mem_valid;
    logic                  mem_ready;
    logic [ADDR_W-1:0]     mem_addr;
    logic [DATA_W-1:0]     mem_data;
    logic                  rd_we;
    logic [ADDR_W-1:0]     rd_addr;
    logic [DATA_W-1:0]     rd_data;
    logic [2**ADDR_W-1:0]  busy_mask;
    logic [CNT_W-1:0]      fifo_count;

    modport slave (
        input  alu_valid, alu_addr, alu_data,
        input  mem_valid, mem_addr, mem_data,
        output alu_stall, mem_ready,
        output rd_we, rd_addr, rd_data,
        output busy_mask, fifo_count
    );

    modport master (
        output alu_valid, alu_addr, alu_data,
        output mem_valid, mem_addr, mem_data,
        input  alu_stall, mem_ready,
        input  rd_we, rd_addr, rd_data,
        input  busy_mask, fifo_count
    );

endinterface

// File: rtl/wb_write_arbiter_fifo.sv
// Synchronous FIFO for long-latency results; exposes occupancy and a mask of
// destination registers held by valid entries.
module wb_result_fifo #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int DEPTH  = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 push,
    input  logic [ADDR_W-1:0]    push_addr,
    input  logic [DATA_W-1:0]    push_data,
    input  logic                 pop,
    output logic [ADDR_W-1:0]    head_addr,
    output logic [DATA_W-1:0]    head_data,
    output logic                 empty,
    output logic                 full,
    output logic [CNT_W-1:0]     count,
    output logic [2**ADDR_W-1:0] busy_mask
);
    logic [ADDR_W-1:0] addr_mem [DEPTH];
    logic [DATA_W-1:0] data_mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  cnt;
    logic [PTR_W-1:0]  offs;

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) begin
                addr_mem[wr_ptr] <= push_addr;
                data_mem[wr_ptr] <= push_data;
                wr_ptr           <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    // An entry is live when its distance from the read pointer is below count;
    // pointer arithmetic wraps naturally because DEPTH is a power of two.
    always_comb begin
        busy_mask = '0;
        offs      = '0;
        for (int i = 0; i < DEPTH; i++) begin
            offs = PTR_W'(i) - rd_ptr;
            if ({1'b0, offs} < cnt) begin
                busy_mask[addr_mem[i]] = 1'b1;
            end
        end
    end

    assign head_addr = addr_mem[rd_ptr];
    assign head_data = data_mem[rd_ptr];
    assign empty     = (cnt == '0);
    assign full      = (cnt == CNT_W'(DEPTH));
    assign count     = cnt;

endmodule

// File: rtl/wb_write_arbiter.sv
// Owns the register-file write port: ALU results win unless the buffered
// long-latency head has waited STARVE_LIMIT cycles.
module wb_write_arbiter
    import wb_write_arbiter_pkg::*;
#(
    parameter int DATA_W       = DEF_DATA_W,
    parameter int ADDR_W       = DEF_ADDR_W,
    parameter int QDEPTH       = DEF_QDEPTH,
    parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
    input  logic               clk,
    input  logic               reset,
    wb_write_arbiter_if.slave  bus
);
    localparam int CNT_W = $clog2(QDEPTH + 1);
    localparam int SC_W  = $clog2(STARVE_LIMIT + 1);

    logic                  fifo_push;
    logic                  fifo_pop;
    logic                  fifo_empty;
    logic                  fifo_full;
    logic [ADDR_W-1:0]     head_addr;
    logic [DATA_W-1:0]     head_data;
    logic [CNT_W-1:0]      fifo_count;
    logic [2**ADDR_W-1:0]  busy_mask;
    logic [SC_W-1:0]       starve_cnt;
    logic                  alu_stall;
    logic                  mem_ready;
    logic                  alu_ok;
    logic                  rd_we_q;
    logic [ADDR_W-1:0]     rd_addr_q;
    logic [DATA_W-1:0]     rd_data_q;

    assign alu_stall = !reset && (starve_cnt == SC_W'(STARVE_LIMIT));
    assign mem_ready = !reset && !fifo_full;

    // Writes to r0 are dropped at the door on both paths.
    assign fifo_push = bus.mem_valid && mem_ready && (bus.mem_addr != '0);
    assign alu_ok    = bus.alu_valid && (bus.alu_addr != '0) && !alu_stall;
    assign fifo_pop  = !fifo_empty && !alu_ok;

    wb_result_fifo #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (QDEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (fifo_push),
        .push_addr (bus.mem_addr),
        .push_data (bus.mem_data),
        .pop       (fifo_pop),
        .head_addr (head_addr),
        .head_data (head_data),
        .empty     (fifo_empty),
        .full      (fifo_full),
        .count     (fifo_count),
        .busy_mask (busy_mask)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_we_q    <= 1'b0;
            rd_addr_q  <= '0;
            rd_data_q  <= '0;
            starve_cnt <= '0;
        end else begin
            rd_we_q <= fifo_pop || alu_ok;
            if (fifo_pop) begin
                rd_addr_q <= head_addr;
                rd_data_q <= head_data;
            end else if (alu_ok) begin
                rd_addr_q <= bus.alu_addr;
                rd_data_q <= bus.alu_data;
            end
            if (fifo_empty || fifo_pop) begin
                starve_cnt <= '0;
            end else if (starve_cnt != SC_W'(STARVE_LIMIT)) begin
                starve_cnt <= starve_cnt + 1'b1;
            end
        end
    end

    assign bus.alu_stall  = alu_stall;
    assign bus.mem_ready  = mem_ready;
    assign bus.rd_we      = rd_we_q;
    assign bus.rd_addr    = rd_addr_q;
    assign bus.rd_data    = rd_data_q;
    assign bus.busy_mask  = busy_mask;
    assign bus.fifo_count = fifo_count;

endmodule

// File: tb/tb_wb_write_arbiter.sv
// Scoreboard bench for wb_write_arbiter: a queue-level model predicts each
// register-file write and the per-cycle status outputs.
module tb_wb_write_arbiter;
    import wb_write_arbiter_pkg::*;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int QD = 4;
    localparam int SL = 3;
    localparam int NR = 32;

    typedef struct {
        int      stamp;
        wr_req_t req;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    wb_write_arbiter_if #(.DATA_W(DW), .ADDR_W(AW), .QDEPTH(QD)) bus ();

    wb_write_arbiter #(
        .DATA_W       (DW),
        .ADDR_W       (AW),
        .QDEPTH       (QD),
        .STARVE_LIMIT (SL)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    wr_req_t mq[$];
    exp_t    sb[$];
    int      waitc = 0;
    int      n_edges = 0;
    int      n_vec = 0;
    int      n_err = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (edge %0d)", name, act, exp, n_edges);
        end
    endtask

    function automatic logic [NR-1:0] model_mask();
        logic [NR-1:0] m;
        m = '0;
        foreach (mq[i]) m[mq[i].addr] = 1'b1;
        return m;
    endfunction

    // One clock of stimulus; the model decides what the next edge must write.
    task automatic step(input bit rst, input bit av, input logic [AW-1:0] aa,
                        input logic [DW-1:0] ad, input bit mv,
                        input logic [AW-1:0] ma, input logic [DW-1:0] md,
                        output bit acc);
        bit            e_ready;
        bit            e_stall;
        bit            alu_ok;
        int            e_count;
        logic [NR-1:0] e_mask;
        exp_t          e;
        wr_req_t       w;
        @(posedge clk);
        #1;
        reset         = rst;
        bus.alu_valid = av;
        bus.alu_addr  = aa;
        bus.alu_data  = ad;
        bus.mem_valid = mv;
        bus.mem_addr  = ma;
        bus.mem_data  = md;
        e_ready = !rst && (mq.size() != QD);
        e_stall = !rst && (waitc == SL);
        e_count = mq.size();
        e_mask  = model_mask();
        acc     = mv && e_ready;
        if (rst) begin
            mq.delete();
            waitc = 0;
        end else begin
            alu_ok = av && (aa != 0) && !e_stall;
            e.stamp = n_edges + 1;
            if (mq.size() != 0 && !alu_ok) begin
                e.req = mq.pop_front();
                sb.push_back(e);
                waitc = 0;
            end else begin
                if (alu_ok) begin
                    e.req.addr = aa;
                    e.req.data = ad;
                    sb.push_back(e);
                end
                if (mq.size() == 0) waitc = 0;
                else if (waitc < SL) waitc++;
            end
            if (acc && ma != 0) begin
                w.addr = ma;
                w.data = md;
                mq.push_back(w);
            end
        end
        @(negedge clk);
        check("mem_ready", bus.mem_ready, e_ready);
        check("alu_stall", bus.alu_stall, e_stall);
        check("fifo_count", bus.fifo_count, e_count);
        check("busy_mask", bus.busy_mask, e_mask);
        if (av && aa != 0 && !rst)
            check("raw_hazard", bus.busy_mask[aa], 1'b0);
    endtask

    task automatic idle(input int n);
        bit acc;
        for (int i = 0; i < n; i++) step(0, 0, '0, '0, 0, '0, '0, acc);
    endtask

    // Monitor: every edge either matches the scoreboard head or must be quiet.
    initial begin
        logic [AW-1:0] last_a;
        logic [DW-1:0] last_d;
        bit            r;
        exp_t          e;
        last_a = '0;
        last_d = '0;
        forever begin
            @(posedge clk);
            n_edges++;
            r = reset;
            @(negedge clk);
            if (r) begin
                check("rst_rd_we", bus.rd_we, 1'b0);
                check("rst_rd_addr", bus.rd_addr, '0);
                check("rst_rd_data", bus.rd_data, '0);
                last_a = '0;
                last_d = '0;
            end else if (sb.size() != 0 && sb[0].stamp == n_edges) begin
                e = sb.pop_front();
                check("rd_we", bus.rd_we, 1'b1);
                check("rd_addr", bus.rd_addr, e.req.addr);
                check("rd_data", bus.rd_data, e.req.data);
                last_a = e.req.addr;
                last_d = e.req.data;
            end else begin
                check("rd_we_idle", bus.rd_we, 1'b0);
                check("rd_addr_hold", bus.rd_addr, last_a);
                check("rd_data_hold", bus.rd_data, last_d);
            end
        end
    end

    initial begin
        bit            acc;
        int            pushed;
        bit            have_req;
        logic [AW-1:0] req_a;
        logic [DW-1:0] req_d;
        bit            av;
        logic [AW-1:0] aa;
        logic [NR-1:0] m;
        int            dens;

        bus.alu_valid = 1'b0;
        bus.alu_addr  = '0;
        bus.alu_data  = '0;
        bus.mem_valid = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_data  = '0;

        step(1, 0, '0, '0, 0, '0, '0, acc);
        step(1, 0, '0, '0, 0, '0, '0, acc);
        idle(1);

        step(0, 1, 5'd5, 32'hDEADBEEF, 0, '0, '0, acc);
        step(0, 1, 5'd0, 32'h0BADF00D, 0, '0, '0, acc);
        idle(2);

        step(0, 0, '0, '0, 1, 5'd7, 32'h00001234, acc);
        idle(4);

        // ALU saturates the port while four loads queue up behind it.
        pushed = 0;
        for (int i = 0; i < 16; i++) begin
            step(0, 1, AW'(1 + i % 9), $urandom, pushed < 4, AW'(10 + pushed), $urandom, acc);
            if (acc) pushed++;
        end
        idle(6);

        // Reset with two entries buffered: they must never reach the port.
        step(0, 1, 5'd20, $urandom, 1, 5'd14, $urandom, acc);
        step(0, 1, 5'd21, $urandom, 1, 5'd15, $urandom, acc);
        step(1, 1, 5'd22, $urandom, 0, '0, '0, acc);
        idle(4);

        step(0, 0, '0, '0, 1, 5'd0, 32'hFFFFFFFF, acc);
        idle(2);
        step(0, 1, 5'd3, $urandom, 1, 5'd16, $urandom, acc);
        step(0, 1, 5'd4, $urandom, 1, 5'd18, $urandom, acc);
        step(0, 0, '0, '0, 1, 5'd17, $urandom, acc);
        idle(6);

        have_req = 0;
        req_a    = '0;
        req_d    = '0;
        for (int i = 0; i < 3000; i++) begin
            dens = (i / 500) % 3 == 0 ? 30 : ((i / 500) % 3 == 1 ? 70 : 95);
            if (!have_req && $urandom_range(0, 2) == 0) begin
                have_req = 1;
                req_a    = AW'($urandom_range(0, NR - 1));
                req_d    = $urandom;
            end
            m  = model_mask();
            aa = AW'($urandom_range(0, NR - 1));
            av = ($urandom_range(0, 99) < dens) && !m[aa];
            step($urandom_range(0, 399) == 0, av, aa, $urandom, have_req, req_a, req_d, acc);
            if (acc) have_req = 0;
        end
        idle(20);
        check("sb_drained", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/wb_write_arbiter.md
Name: wb_write_arbiter

Overview:
Writeback-side arbiter that owns the single register-file write port (rd_we/rd_addr/rd_data). It merges single-cycle ALU results, which have priority, with long-latency results (loads, multiply) that arrive over a valid/ready handshake and are buffered in a small FIFO. It exports a per-register pending mask so decode can stall on RAW/WAW hazards against buffered results, and an anti-starvation stall that freezes the ALU path.

Parameters:
DATA_W, 32, data width of a register write
ADDR_W, 5, register address width (2**ADDR_W registers)
QDEPTH, 4, long-latency result FIFO depth (power of 2, >=2)
STARVE_LIMIT, 3, cycles a non-empty FIFO head may wait before alu_stall is raised

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
alu_valid  input  1  ALU result present this cycle (no backpressure except alu_stall)
alu_addr  input  ADDR_W  ALU destination register
alu_data  input  DATA_W  ALU result
alu_stall  output  1  upstream must hold; alu_valid is ignored while high
mem_valid  input  1  long-latency result offered
mem_ready  output  1  FIFO can accept
mem_addr  input  ADDR_W  long-latency destination register
mem_data  input  DATA_W  long-latency result
rd_we  output  1  register-file write enable (registered)
rd_addr  output  ADDR_W  register-file write address (registered)
rd_data  output  DATA_W  register-file write data (registered)
busy_mask  output  2**ADDR_W  bit i=1 when a valid FIFO entry targets register i
fifo_count  output  clog2(QDEPTH+1)  number of valid FIFO entries

Behaviour:
- Reset (clk edge with reset=1): FIFO flushed (pointers and count 0), starve counter 0. rd_we=0, rd_addr=0, rd_data=0, busy_mask=0, fifo_count=0. mem_ready=0 and alu_stall=0 while reset is high. Buffered writes are discarded on reset mid-operation.
- mem_ready = !reset && fifo_count!=QDEPTH (state only, no dependency on mem_valid).
- Accept: mem_valid && mem_ready. If mem_addr==0, the handshake completes but nothing is enqueued. Otherwise {addr,data} is pushed at the tail.
- No FIFO bypass. An accepted entry is visible the next cycle, so the earliest rd_we is 2 cycles after acceptance.
- alu_stall = (starve_cnt == STARVE_LIMIT). It is a function of state only, so there is no combinational path from inputs.
- Per-cycle selection, result registered onto rd_* at the next edge (1-cycle latency):
  1. if alu_stall: pop FIFO head and write it; alu_valid is ignored.
  2. else if alu_valid && alu_addr!=0: write ALU result; FIFO holds.
  3. else if FIFO non-empty: pop head and write it.
  4. else rd_we=0.
- When rd_we=0, rd_addr and rd_data hold their previous values.
- ALU writes to r0 produce rd_we=0 and count as idle for the FIFO (case 3 may pop).
- Starve counter: cleared when the FIFO is empty or the head is popped. Otherwise it increments each cycle, saturating at STARVE_LIMIT.
- Simultaneous push and pop: both occur. fifo_count is unchanged; pointers advance modulo QDEPTH.
- Push while full cannot occur (mem_ready=0).
- busy_mask: combinational OR of one-hot(addr) over valid entries. A popped entry's bit clears at the same edge its rd_we rises. Duplicate addresses keep the bit set until the last one pops.
- Ordering: FIFO entries write in acceptance order. Decode must stall any instruction whose rs/rt/rd hits busy_mask, so ALU and FIFO writes never race on one register. This block does not check that rule; bench assertion only.

Decomposition:
- Shared package: DATA_W/ADDR_W defaults, write-request struct {addr,data}, NUM_REGS=32 constant.
- One natural sub-module: wb_result_fifo (parameterised sync FIFO with count and per-entry valid/addr visibility for busy_mask). The arbiter, starve counter and output register stay in the top.

Test Plan:
1. Hold reset 2 cycles -> rd_we=0, rd_addr=0, rd_data=0, busy_mask=0, fifo_count=0, mem_ready=0 during reset, mem_ready=1 the cycle after release.
2. alu_valid, alu_addr=5, alu_data=0xDEADBEEF -> next cycle rd_we=1, rd_addr=5, rd_data=0xDEADBEEF. Then alu_addr=0 -> rd_we=0.
3. ALU idle, mem handshake addr=7, data=0x00001234 -> busy_mask[7]=1 and fifo_count=1 next cycle. rd_we=1, rd_addr=7 two cycles after acceptance, with busy_mask[7]=0 in that same cycle.
4. alu_valid continuously to r1..r9 while pushing 4 mem entries (r10..r13) -> mem_ready=0 at fifo_count=4. alu_stall rises after 3 cycles of head waiting. Next cycle rd_addr=10, ALU input ignored, counter cleared. Entries drain in order r10,r11,r12,r13.
5. Push 2 entries, assert reset for 1 cycle -> fifo_count=0, busy_mask=0, no rd_we for the flushed entries afterwards.
6. mem handshake with addr=0, data=0xFFFFFFFF -> handshake completes, fifo_count stays 0, no rd_we. Simultaneous push+pop at fifo_count=2 -> count stays 2.
